// File: rtl/g729_enc_pkg.sv
// Shared G.729 encoder definitions: frame geometry, sample type, scheduler
// FSM encoding and a saturating magnitude helper.
package g729_enc_pkg;

    localparam int unsigned FRAME_LEN = 80;
    localparam int unsigned SUBFR_LEN = 40;
    localparam int unsigned SAMPLE_W  = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILT = 2'd1,
        ST_DONE = 2'd2,
        ST_CLR  = 2'd3
    } fsm_state_t;

    // |s| with the single unrepresentable case (-32768) clamped to 32767
    function automatic logic [SAMPLE_W-1:0] abs_sat(input sample_t s);
        logic [SAMPLE_W-1:0] r;
        if (s == sample_t'({1'b1, {(SAMPLE_W-1){1'b0}}})) begin
            r = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (s < 0) begin
            r = SAMPLE_W'(-s);
        end else begin
            r = SAMPLE_W'(s);
        end
        return r;
    endfunction

endpackage

// File: rtl/hpf_peak_track.sv
// Running peak of |sample| over one frame; the peak is latched on the last
// write of each frame and held until the next frame completes.
module hpf_peak_track
    import g729_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        we,
    input  logic        first,
    input  logic        last,
    input  sample_t     wdata,
    output logic [15:0] peak
);

    logic [15:0] mag_c;
    logic [15:0] cand_c;
    logic [15:0] run_q, run_d;
    logic [15:0] peak_q, peak_d;

    // Candidate peak: restart at the first sample of a frame, else running max
    always_comb begin
        mag_c  = abs_sat(wdata);
        cand_c = (first || (mag_c > run_q)) ? mag_c : run_q;
        run_d  = run_q;
        peak_d = peak_q;
        if (clr) begin
            run_d = '0;
        end else if (we) begin
            run_d = cand_c;
            if (last) begin
                peak_d = cand_c;
            end
        end
    end

    // Running and latched peak registers
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            peak_q <= '0;
        end else begin
            run_q  <= run_d;
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;

endmodule

// File: rtl/hpf_frame_sched.sv
// Pre-processing high-pass filter scheduler: accepts PCM samples, strobes the
// external filter once per sample, writes its output into the frame buffer
// and hands each full frame downstream. Filter memory persists across frames
// and is cleared only by rst or clr_req.
// Optional build macro: HPF_PEAK_DETECT_EN adds the frame_peak output.
module hpf_frame_sched #(
    parameter int unsigned FRAME_LEN = 80,
    parameter int unsigned AW        = 7,
    parameter int unsigned FCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready,
    input  logic              clr_req,
    output logic [15:0]       hpf_audio_in,
    output logic              hpf_ce,
    output logic              hpf_rst_n,
    input  logic [15:0]       hpf_y,
    output logic              buf_we,
    output logic [AW-1:0]     buf_addr,
    output logic [15:0]       buf_wdata,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic [FCNT_W-1:0] frame_cnt
`ifdef HPF_PEAK_DETECT_EN
    ,
    output logic [15:0]       frame_peak
`endif
);

    import g729_enc_pkg::*;

    fsm_state_t        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    sample_t           audio_q, audio_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              last_c;

    assign last_c = (idx_q == AW'(FRAME_LEN - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear beats a new sample in IDLE; DONE waits only for ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLR;
                end else if (in_valid) begin
                    state_d = ST_FILT;
                end
            end
            ST_FILT: state_d = last_c ? ST_DONE : ST_IDLE;
            ST_DONE: begin
                if (frame_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: filter strobe and buffer write share the FILT cycle
    always_comb begin
        in_ready    = 1'b0;
        hpf_ce      = 1'b0;
        buf_we      = 1'b0;
        frame_valid = 1'b0;
        hpf_rst_n   = 1'b1;
        if (rst) begin
            hpf_rst_n = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: in_ready = ~clr_req;
                ST_FILT: begin
                    hpf_ce = 1'b1;
                    buf_we = 1'b1;
                end
                ST_DONE: frame_valid = 1'b1;
                ST_CLR:  hpf_rst_n   = 1'b0;
                default: ;
            endcase
        end
    end

    // Datapath next values: sample capture, write index, frame counter
    always_comb begin
        idx_d   = idx_q;
        audio_d = audio_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!clr_req && in_valid) begin
                    audio_d = sample_t'(in_data);
                end
            end
            ST_FILT: begin
                if (last_c) begin
                    idx_d  = '0;
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_CLR: begin
                idx_d   = '0;
                audio_d = '0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            audio_q <= '0;
            fcnt_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            audio_q <= audio_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign hpf_audio_in = audio_q;
    assign buf_addr     = idx_q;
    assign buf_wdata    = hpf_y;
    assign frame_cnt    = fcnt_q;

`ifdef HPF_PEAK_DETECT_EN
    logic clr_c;
    logic first_c;

    assign clr_c   = (state_q == ST_CLR);
    assign first_c = (idx_q == '0);

    hpf_peak_track u_peak (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_c),
        .we    (buf_we),
        .first (first_c),
        .last  (last_c),
        .wdata (sample_t'(hpf_y)),
        .peak  (frame_peak)
    );
`endif

endmodule
